// File: rtl/clint_mtimer.sv
// Machine timer / software-interrupt block: 64-bit mtime with prescaler,
// mtimecmp compare driving a registered mtip, and msip, behind a tiny word-addressed bus.
module clint_mtimer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        mtip,
  output logic        msip
);

  localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);

  logic [15:0] psc;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtime_inc;
  logic [63:0] mtimecmp;
  logic        msip_q;
  logic        mtip_q;
  logic        wr;
  logic        rd;
  logic [31:0] rd_mux;
  logic [31:0] rdata_p1;
  logic        vld_p1;

  assign wr        = req & wr_en;
  assign rd        = req & ~wr_en;
  assign tick      = (psc == PSC_LAST);
  assign mtime_inc = mtime + 64'd1;

  always_ff @(posedge clk) begin
    if (rst || tick) psc <= 16'd0;
    else             psc <= psc + 16'd1;
  end

  // A half-word write wins over the increment; the other half holds, no carry.
  always_ff @(posedge clk) begin
    if (rst)                      mtime         <= 64'd0;
    else if (wr && addr == 3'd3)  mtime[31:0]   <= wdata;
    else if (wr && addr == 3'd4)  mtime[63:32]  <= wdata;
    else if (tick)                mtime         <= mtime_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q   <= 1'b0;
      mtip_q   <= 1'b0;
    end else begin
      if (wr && addr == 3'd1) mtimecmp[31:0]  <= wdata;
      if (wr && addr == 3'd2) mtimecmp[63:32] <= wdata;
      if (wr && addr == 3'd0) msip_q          <= wdata[0];
      mtip_q <= (mtime >= mtimecmp);
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      3'd0:    rd_mux = {31'd0, msip_q};
      3'd1:    rd_mux = mtimecmp[31:0];
      3'd2:    rd_mux = mtimecmp[63:32];
      3'd3:    rd_mux = mtime[31:0];
      3'd4:    rd_mux = mtime[63:32];
      default: rd_mux = 32'd0;
    endcase
  end

  // Stage p1: read response, one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= 32'd0;
    end else begin
      vld_p1   <= rd;
      rdata_p1 <= rd ? rd_mux : 32'd0;
    end
  end

  // Masking with rst keeps a response from surfacing in the cycle reset is raised.
  assign rdata_valid = vld_p1 & ~rst;
  assign rdata       = rdata_valid ? rdata_p1 : 32'd0;
  assign mtip        = mtip_q;
  assign msip        = msip_q;

endmodule

// File: tb/tb_clint_mtimer.sv
// Directed bench for clint_mtimer: one instance at PRESCALE=1, one at PRESCALE=4,
// sharing clock, reset and write-data lines with separate request strobes.
module tb_clint_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req1 = 1'b0;
  logic        req4 = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata1, rdata4;
  logic        vld1, vld4, mtip1, mtip4, msip1, msip4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clint_mtimer #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rdata_valid(vld1), .mtip(mtip1), .msip(msip1)
  );

  clint_mtimer #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .rdata_valid(vld4), .mtip(mtip4), .msip(msip4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one request across the next posedge and
  // returns the response visible at the following negedge.
  task automatic access(input bit sel, input bit we, input logic [2:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic v);
    req1 = !sel; req4 = sel; wr_en = we; addr = a; wdata = d;
    @(negedge clk);
    req1 = 1'b0; req4 = 1'b0; wr_en = 1'b0;
    rd = sel ? rdata4 : rdata1;
    v  = sel ? vld4 : vld1;
  endtask

  task automatic rd_chk(input bit sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic v;
    access(sel, 1'b0, a, 32'd0, rd, v);
    check({tag, "_vld"}, 64'(v), 64'd1);
    check(tag, 64'(rd), 64'(exp));
  endtask

  task automatic wr_chk(input bit sel, input logic [2:0] a, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic v;
    access(sel, 1'b1, a, d, rd, v);
    check({tag, "_novld"}, 64'(v), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_rdata", 64'(rdata1), 64'd0);
    check("rst_vld",   64'(vld1),   64'd0);
    check("rst_mtip",  64'(mtip1),  64'd0);
    check("rst_msip",  64'(msip1),  64'd0);
    check("rst_mtip4", 64'(mtip4),  64'd0);

    // Idle count after reset at PRESCALE=1
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mtip", 64'(mtip1), 64'd0);
    end
    rd_chk(1'b0, 3'd3, 32'd10, "idle_mtime_lo");
    rd_chk(1'b0, 3'd4, 32'd0,  "idle_mtime_hi");

    // Carry from low into high word; hi write coincident with increment holds lo
    wr_chk(1'b0, 3'd3, 32'hFFFF_FFFE, "wr_lo");
    wr_chk(1'b0, 3'd4, 32'd0,         "wr_hi");
    idle(2);
    rd_chk(1'b0, 3'd3, 32'd0, "carry_lo");
    rd_chk(1'b0, 3'd4, 32'd1, "carry_hi");

    // Compare and mtip latency
    do_reset();
    wr_chk(1'b0, 3'd2, 32'd0,   "cmp_hi");
    wr_chk(1'b0, 3'd1, 32'd100, "cmp_lo");
    wr_chk(1'b0, 3'd3, 32'd98,  "mt98");
    check("mtip_98", 64'(mtip1), 64'd0);
    idle(1);
    check("mtip_99", 64'(mtip1), 64'd0);
    idle(1);
    check("mtip_100", 64'(mtip1), 64'd0);
    idle(1);
    check("mtip_rise", 64'(mtip1), 64'd1);
    wr_chk(1'b0, 3'd1, 32'd1000, "cmp_1000");
    check("mtip_hold", 64'(mtip1), 64'd1);
    idle(1);
    check("mtip_drop", 64'(mtip1), 64'd0);

    // msip and unmapped addresses
    wr_chk(1'b0, 3'd0, 32'hFFFF_FFFF, "msip_set");
    check("msip_1", 64'(msip1), 64'd1);
    rd_chk(1'b0, 3'd0, 32'd1, "msip_rd");
    wr_chk(1'b0, 3'd0, 32'd0, "msip_clr");
    check("msip_0", 64'(msip1), 64'd0);
    wr_chk(1'b0, 3'd6, 32'hFFFF_FFFF, "wr_a6");
    check("a6_msip", 64'(msip1), 64'd0);
    rd_chk(1'b0, 3'd1, 32'd1000, "a6_cmp");
    rd_chk(1'b0, 3'd6, 32'd0, "rd_a6");
    idle(1);
    check("idle_rdata", 64'(rdata1), 64'd0);
    check("idle_vld",   64'(vld1),   64'd0);

    // Read followed by reset
    wr_chk(1'b0, 3'd0, 32'd1, "pre_msip");
    wr_chk(1'b0, 3'd1, 32'd0, "pre_cmp");
    idle(1);
    check("pre_mtip", 64'(mtip1), 64'd1);
    req1 = 1'b1; wr_en = 1'b0; addr = 3'd3;
    @(negedge clk);
    req1 = 1'b0;
    rst = 1'b1;
    #1;
    check("rr_vld_rstcyc",   64'(vld1),   64'd0);
    check("rr_rdata_rstcyc", 64'(rdata1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rr_vld",   64'(vld1),   64'd0);
    check("rr_rdata", 64'(rdata1), 64'd0);
    check("rr_mtip",  64'(mtip1),  64'd0);
    check("rr_msip",  64'(msip1),  64'd0);
    rd_chk(1'b0, 3'd3, 32'd0,         "rr_mtime");
    rd_chk(1'b0, 3'd2, 32'hFFFF_FFFF, "rr_cmp_hi");

    // Prescaler = 4
    do_reset();
    idle(20);
    rd_chk(1'b1, 3'd3, 32'd5, "p4_mtime5");
    idle(2);
    wr_chk(1'b1, 3'd3, 32'd7, "p4_wr7");
    rd_chk(1'b1, 3'd3, 32'd7, "p4_hold7");
    idle(2);
    rd_chk(1'b1, 3'd3, 32'd7, "p4_still7");
    rd_chk(1'b1, 3'd3, 32'd8, "p4_next8");
    rd_chk(1'b1, 3'd4, 32'd0, "p4_hi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_mtimer.md
CLINT_MTIMER -- requirements
Module: clint_mtimer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1, giving clk cycles per mtime increment; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port req, input, 1, a register access request in this cycle.
REQ-005 The block SHALL have port wr_en, input, 1, with 1 selecting a write and 0 a read; valid only with req.
REQ-006 The block SHALL have port addr, input, 3, the word index of the register.
REQ-007 The block SHALL have port wdata, input, 32, the write data.
REQ-008 The block SHALL have port rdata, output, 32, the read data.
REQ-009 The block SHALL have port rdata_valid, output, 1, a one-cycle pulse qualifying rdata.
REQ-010 The block SHALL have port mtip, output, 1, the machine timer interrupt pending, driving mip.mtip in the CSR unit.
REQ-011 The block SHALL have port msip, output, 1, the machine software interrupt pending, driving mip.msip in the CSR unit.

Function
REQ-012 Register map by addr SHALL be: 0 = msip (bit0 only, other bits read 0), 1 = mtimecmp[31:0], 2 = mtimecmp[63:32], 3 = mtime[31:0], 4 = mtime[63:32].
REQ-013 For addr 5..7, reads SHALL return 0 with rdata_valid, and writes SHALL be ignored.
REQ-014 Writes SHALL take effect at the clock edge ending the req cycle, and SHALL NOT pulse rdata_valid.
REQ-015 A read SHALL assert rdata_valid exactly one cycle after the req cycle, with rdata equal to the register value before that edge.
REQ-016 Back-to-back requests on every cycle SHALL be accepted; there is no stall or backpressure.
REQ-017 When rdata_valid=0, rdata SHALL be 0.
REQ-018 Prescaler: a counter SHALL count 0..PRESCALE-1 and wrap; mtime SHALL increment by 1 on the cycle the counter wraps.
REQ-019 With PRESCALE=1, mtime SHALL increment every cycle.
REQ-020 mtime SHALL be a 64-bit counter with carry from [31:0] into [63:32], and SHALL wrap from 2^64-1 to 0.
REQ-021 When a write to an mtime half and an increment occur in the same cycle, the written half SHALL take wdata.
REQ-022 In that same case, the other half SHALL keep its pre-edge value, with no carry applied.
REQ-023 A write to mtime SHALL NOT reset the prescaler.
REQ-024 mtip SHALL be registered: mtip at cycle n+1 equals (mtime >= mtimecmp, unsigned 64-bit) evaluated on the values at cycle n.
REQ-025 Due to REQ-024, mtip SHALL follow a mtimecmp write, mtime write or crossing increment with exactly one cycle of latency.
REQ-026 msip SHALL equal the stored msip bit directly, with no additional delay beyond the register.
REQ-027 mtip SHALL be level, not sticky; software clears it by raising mtimecmp above mtime.

Reset
REQ-028 While rst=1 at an edge, the next state SHALL be: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, mtip=0, rdata_valid=0, rdata=0.
REQ-029 rst SHALL override any concurrent req.
REQ-030 A read issued in the cycle before rst SHALL NOT produce rdata_valid in the reset cycle.
REQ-031 mtime SHALL resume incrementing on the first cycle after rst deasserts, following REQ-018.

Verification
REQ-032 Reset then idle 10 cycles with PRESCALE=1 -> a read of addr 3 returns 10 (±0 per REQ-015 timing), a read of addr 4 returns 0, and mtip=0 throughout.
REQ-033 Write addr3=32'hFFFF_FFFE and addr4=0, PRESCALE=1 -> two cycles later mtime = 64'h1_0000_0000, with the carry into the high word verified.
REQ-034 Write mtimecmp hi=0, lo=100, then mtime=98 -> mtip rises the cycle after mtime reaches 100; writing mtimecmp lo=1000 drops mtip one cycle later.
REQ-035 PRESCALE=4, mtime=0 after reset -> mtime reads 5 after 20 cycles; a write mtime=7 coincident with a wrap holds 7, with no 8 that cycle.
REQ-036 Write addr0=32'hFFFF_FFFF -> msip=1, and a read of addr0 returns 1; write 0 -> msip=0; a write to addr 6 changes no state, and a read of addr 6 returns 0 with rdata_valid.
REQ-037 Read issued, then rst in the following cycle -> no rdata_valid pulse, and all outputs at reset values per REQ-028.
